byte_serial_right_shifter: RTL and testbench

//   Multi-cycle right-shift unit for the byte ALU: the right-going counterpart of the

---
 rtl/byte_serial_right_shifter_pkg.sv | 19 +
 rtl/byte_serial_right_shifter_step.sv | 28 ++
 rtl/byte_serial_right_shifter.sv | 90 +++++++++
 tb/tb_byte_serial_right_shifter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/byte_serial_right_shifter_pkg.sv
// Shared definitions for the byte-serial right shifter: FSM states, mode codes
// and the any-bit-set helper used to derive the zero flag.
package byte_serial_right_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] SHR_LOGIC = 2'b00;
  localparam logic [1:0] SHR_ARITH = 2'b01;
  localparam logic [1:0] SHR_ROT   = 2'b10;

  function automatic logic any_set(input logic [63:0] value);
    return |value;
  endfunction

endpackage

// File: rtl/byte_serial_right_shifter_step.sv
// One-position right shift: logical, arithmetic or rotate. The reserved mode
// code falls back to logical.
module byte_serial_right_shifter_step
  import byte_serial_right_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  logic fill_s;

  // Select the bit entering at the MSB and form the shifted word.
  always_comb begin
    fill_s = 1'b0;
    case (mode)
      SHR_ARITH: fill_s = A[WIDTH-1];
      SHR_ROT:   fill_s = A[0];
      default:   fill_s = 1'b0;
    endcase
    out   = {fill_s, A[WIDTH-1:1]};
    carry = A[0];
  end

endmodule

// File: rtl/byte_serial_right_shifter.sv
// Multi-cycle right shifter: accepts operand/amount/mode on a valid/ready
// handshake, shifts one position per clock, returns result, carry and zero.
module byte_serial_right_shifter
  import byte_serial_right_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  state_t           state_r;
  logic [WIDTH-1:0] data_r;
  logic [AMT_W-1:0] cnt_r;
  logic [1:0]       mode_r;
  logic             carry_r;
  logic [WIDTH-1:0] step_out_s;
  logic             step_carry_s;

  byte_serial_right_shifter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .A     (data_r),
    .mode  (mode_r),
    .out   (step_out_s),
    .carry (step_carry_s)
  );

  // Control FSM and datapath registers; inputs are captured only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      data_r  <= '0;
      cnt_r   <= '0;
      mode_r  <= SHR_LOGIC;
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r  <= A;
            cnt_r   <= amount;
            mode_r  <= mode;
            carry_r <= 1'b0;
            state_r <= (amount == '0) ? DONE : SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          data_r  <= step_out_s;
          carry_r <= step_carry_s;
          cnt_r   <= cnt_r - AMT_W'(1);
          if (cnt_r == AMT_W'(1)) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out       = data_r;
  assign carry     = carry_r;
  // Zero is a pure decode of the result register, so it is 1 out of reset.
  assign zero      = ~any_set(64'(data_r));

endmodule

// File: tb/tb_byte_serial_right_shifter.sv
// Scoreboard bench: stimulus pushes hand-computed results into a queue, a
// monitor pops and compares on every output handshake.
module tb_byte_serial_right_shifter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [2:0] amount;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       carry;
  logic       zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [9:0] exp_q[$];

  byte_serial_right_shifter #(.WIDTH(8), .AMT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .amount    (amount),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out), 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("out", 32'(out), 32'(e[9:2]));
        check("carry", 32'(carry), 32'(e[1]));
        check("zero", 32'(zero), 32'(e[0]));
      end
    end
  end

  task automatic issue(input logic [7:0] a_v, input logic [2:0] amt_v, input logic [1:0] mode_v,
                       input logic [7:0] exp_out, input logic exp_carry, input logic exp_zero,
                       input bit churn);
    int t0;
    bit seen;
    @(posedge clk); #1;
    A = a_v; amount = amt_v; mode = mode_v; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_at_issue", 32'(in_ready), 32'd1);
    t0 = cyc;
    exp_q.push_back({exp_out, exp_carry, exp_zero});
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (churn) begin
        A = 8'($urandom); amount = 3'($urandom); mode = 2'($urandom);
      end
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("out_valid_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc - t0), 32'(amt_v) + 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = 8'h00; amount = 3'd0; mode = 2'b00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_carry", 32'(carry), 32'd0);
    check("reset_zero", 32'(zero), 32'd1);
    rst = 1'b0;

    // Directed vectors: A, amount, mode, out, carry, zero.
    issue(8'hB6, 3'd3, 2'b00, 8'h16, 1'b1, 1'b0, 1'b0);
    issue(8'h90, 3'd2, 2'b01, 8'hE4, 1'b0, 1'b0, 1'b0);
    issue(8'h81, 3'd1, 2'b10, 8'hC0, 1'b1, 1'b0, 1'b0);
    issue(8'h5A, 3'd0, 2'b00, 8'h5A, 1'b0, 1'b0, 1'b0);
    issue(8'h01, 3'd1, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);
    issue(8'h80, 3'd7, 2'b01, 8'hFF, 1'b0, 1'b0, 1'b0);
    issue(8'h01, 3'd7, 2'b10, 8'h02, 1'b0, 1'b0, 1'b0);
    issue(8'hF8, 3'd4, 2'b11, 8'h0F, 1'b1, 1'b0, 1'b0);
    issue(8'hB6, 3'd3, 2'b10, 8'hD6, 1'b1, 1'b0, 1'b0);
    issue(8'hFF, 3'd7, 2'b00, 8'h01, 1'b1, 1'b0, 1'b0);
    // Input churn after accept must not disturb the sampled request.
    issue(8'hB6, 3'd3, 2'b00, 8'h16, 1'b1, 1'b0, 1'b1);
    issue(8'h90, 3'd5, 2'b01, 8'hFC, 1'b1, 1'b0, 1'b1);
    issue(8'h0C, 3'd2, 2'b10, 8'h03, 1'b0, 1'b0, 1'b1);

    // Backpressure: hold result in DONE while a new request is offered.
    @(posedge clk); #1;
    A = 8'h3C; amount = 3'd2; mode = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    exp_q.push_back({8'h0F, 1'b0, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("bp_valid_seen", 32'(seen), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; A = 8'hAA; amount = 3'd1; mode = 2'b01;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out", 32'(out), 32'h0F);
      check("bp_carry", 32'(carry), 32'd0);
      check("bp_zero", 32'(zero), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_after_idle", 32'({in_ready, out_valid}), 32'b10);
    end

    // Reset in the middle of a long shift discards the request.
    @(posedge clk); #1;
    A = 8'hFF; amount = 3'd7; mode = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    issue(8'h96, 3'd4, 2'b01, 8'hF9, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
